// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity, 1/2 stop bits
// and a first-word-fall-through FIFO that tags each word with parity/framing errors.
module uart_rx_fifo #(
    parameter int C_CLK_FRQ         = 100_000_000,
    parameter int C_UART_RATE       = 1_000_000,
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_UART_PARITY     = 1,
    parameter int C_UART_STOP       = 1,
    parameter int C_FIFO_DEPTH      = 16
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            rx,
    output logic [C_UART_DATA_WIDTH-1:0]    m_data,
    output logic                            m_perr,
    output logic                            m_ferr,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            overrun,
    output logic                            break_det,
    output logic [$clog2(C_FIFO_DEPTH):0]   fill
);

    localparam int C_PERIOD = C_CLK_FRQ / C_UART_RATE;
    localparam int CW       = $clog2(C_PERIOD);
    localparam int BW       = $clog2(C_UART_DATA_WIDTH);
    localparam int AW       = $clog2(C_FIFO_DEPTH);
    localparam int FW       = AW + 1;
    localparam int EW       = C_UART_DATA_WIDTH + 2;

    localparam logic [CW-1:0] SMP0     = CW'(C_PERIOD / 2 - 1);
    localparam logic [CW-1:0] SMP1     = CW'(C_PERIOD / 2);
    localparam logic [CW-1:0] SMP2     = CW'(C_PERIOD / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(C_PERIOD - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(C_UART_DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(C_UART_STOP - 1);
    localparam logic [FW-1:0] FULL_CNT  = FW'(C_FIFO_DEPTH);
    localparam logic          HAS_PAR   = (C_UART_PARITY != 0);
    localparam logic          ODD_PAR   = (C_UART_PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK,
        WAITHI
    } state_t;

    state_t state, next_state;

    logic                         rx_meta, rx_sync;
    logic [CW-1:0]                cnt;
    logic                         smp0, smp1;
    logic                         vote, sample_pt;
    logic [BW-1:0]                bit_cnt;
    logic [C_UART_DATA_WIDTH-1:0] shreg;
    logic                         perr, ferr, any_one;
    logic                         push, brk_evt;

    logic [EW-1:0]                mem [C_FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [FW-1:0]                count;
    logic                         full, pop, push_ok;

    // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign sample_pt = (cnt == SMP2);
    assign vote      = (smp0 & smp1) | (smp0 & rx_sync) | (smp1 & rx_sync);

    // The bit-cycle counter runs continuously across bit states so that state
    // changes right after a sample do not disturb the bit grid.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt  <= '0;
            smp0 <= 1'b1;
            smp1 <= 1'b1;
        end else begin
            if (state == START || state == DATA || state == PARITY || state == STOP)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            else
                cnt <= '0;
            if (cnt == SMP0) smp0 <= rx_sync;
            if (cnt == SMP1) smp1 <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            any_one <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    perr    <= 1'b0;
                    ferr    <= 1'b0;
                    any_one <= 1'b0;
                end
                DATA: if (sample_pt) begin
                    shreg   <= {vote, shreg[C_UART_DATA_WIDTH-1:1]};
                    any_one <= any_one | vote;
                    bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
                end
                PARITY: if (sample_pt) begin
                    perr    <= vote ^ (^shreg) ^ ODD_PAR;
                    any_one <= any_one | vote;
                end
                STOP: if (sample_pt) begin
                    if (!vote) ferr <= 1'b1;
                    any_one <= any_one | vote;
                    bit_cnt <= bit_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_sync) next_state = START;
            START:   if (sample_pt) next_state = vote ? IDLE : DATA;
            DATA:    if (sample_pt && bit_cnt == DATA_LAST) next_state = HAS_PAR ? PARITY : STOP;
            PARITY:  if (sample_pt) next_state = STOP;
            STOP:    if (sample_pt && bit_cnt == STOP_LAST) next_state = CHECK;
            CHECK:   next_state = (!any_one || ferr) ? WAITHI : IDLE;
            WAITHI:  if (rx_sync) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push    = 1'b0;
        brk_evt = 1'b0;
        if (state == CHECK) begin
            push    = any_one;
            brk_evt = !any_one;
        end
    end

    assign full    = (count == FULL_CNT);
    assign pop     = m_valid && m_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {perr, ferr, shreg};
    end

    // A push into a full FIFO still succeeds when the head is popped on the same edge.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + FW'(1);
                2'b01:   count <= count - FW'(1);
                default: ;
            endcase
            overrun   <= push && full && !pop;
            break_det <= brk_evt;
        end
    end

    assign m_valid = (count != '0);
    assign fill    = count;
    assign m_data  = m_valid ? mem[rd_ptr][C_UART_DATA_WIDTH-1:0] : '0;
    assign m_perr  = m_valid ? mem[rd_ptr][EW-1] : 1'b0;
    assign m_ferr  = m_valid ? mem[rd_ptr][EW-2] : 1'b0;

endmodule
